// File: rtl/async_pkg.sv
// Shared definitions for the buffered dataflow operator: read-path op encodings
// and elaboration helpers.
package async_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        OP_REG  = 2'd0,
        OP_ADDI = 2'd1,
        OP_SUBI = 2'd2,
        OP_MULI = 2'd3
    } op_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << r) < value) begin
                r = r + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Work at MAX_W bits; callers truncate, which gives the same result as wrapping
    // modulo 2^data_width for add, subtract and multiply.
    function automatic logic [MAX_W-1:0] apply_op(input op_e sel,
                                                  input logic [MAX_W-1:0] x,
                                                  input logic [MAX_W-1:0] imm);
        logic [MAX_W-1:0] res;
        case (sel)
            OP_ADDI: res = x + imm;
            OP_SUBI: res = x - imm;
            OP_MULI: res = x * imm;
            default: res = x;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/async_fifo_operator_chk.sv
// Simulation-only protocol checks for the operator's upstream handshake.
module async_fifo_operator_chk #(
    parameter int depth     = 4,
    parameter int occ_width = 3
) (
    input logic                 clk,
    input logic                 rst,
    input logic                 req_l,
    input logic                 ack_l,
    input logic [occ_width-1:0] occupancy
);

    ack_without_req: assert property (@(posedge clk) disable iff (rst) ack_l |-> req_l)
        else $error("ack_l seen without outstanding req_l");

    occupancy_bound: assert property (@(posedge clk) disable iff (rst)
        occupancy <= occ_width'(depth))
        else $error("occupancy above depth");

endmodule

// File: rtl/async_fifo_read_port.sv
// One consumer's view of the shared buffer: its own read pointer, fill count,
// one-cycle ack pulse and held output token.
module async_fifo_read_port
    import async_pkg::*;
#(
    parameter int          data_width = 32,
    parameter int          ptr_width  = 3,
    parameter op_e         op_sel     = OP_REG,
    parameter logic [63:0] immediate  = 64'd0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ptr_width-1:0]  wr_ptr,
    input  logic [data_width-1:0] rd_word,
    input  logic                  req,
    output logic [ptr_width-1:0]  rd_ptr,
    output logic [ptr_width-1:0]  cnt,
    output logic                  ack,
    output logic [data_width-1:0] dout
);

    logic [ptr_width-1:0]  rd_ptr_r;
    logic                  ack_pulse_r;
    logic [data_width-1:0] dout_r;
    logic [ptr_width-1:0]  cnt_s;
    logic [data_width-1:0] f_s;
    logic                  take_s;

    // The count uses the write pointer from before this cycle's write, so the
    // entry being written now can never be read in the same cycle.
    assign cnt_s  = wr_ptr - rd_ptr_r;
    assign f_s    = data_width'(apply_op(op_sel, MAX_W'(rd_word), immediate));
    assign take_s = req && (cnt_s != '0) && !ack_pulse_r;

    // Pointer advance and ack/dout registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r    <= '0;
            ack_pulse_r <= 1'b0;
            dout_r      <= '0;
        end else if (take_s) begin
            rd_ptr_r    <= rd_ptr_r + ptr_width'(1);
            ack_pulse_r <= 1'b1;
            dout_r      <= f_s;
        end else begin
            ack_pulse_r <= 1'b0;
        end
    end

    assign rd_ptr = rd_ptr_r;
    assign cnt    = cnt_s;
    assign ack    = ack_pulse_r;
    assign dout   = dout_r;

endmodule

// File: rtl/async_fifo_operator.sv
// Multi-entry pull-handshake buffer with lazy fan-out to output_size consumers
// and an optional immediate op on the read path.
module async_fifo_operator
    import async_pkg::*;
#(
    parameter int          data_width  = 32,
    parameter int          depth       = 4,
    parameter int          output_size = 1,
    parameter string       op          = "reg",
    parameter logic [63:0] immediate   = 64'd0
) (
    input  logic                              clk,
    input  logic                              rst,
    output logic                              req_l,
    input  logic                              ack_l,
    input  logic [data_width-1:0]             din,
    input  logic [output_size-1:0]            req_r,
    output logic [output_size-1:0]            ack_r,
    output logic [data_width*output_size-1:0] dout,
    output logic [clog2(depth):0]             occupancy
);

    localparam int  aw    = clog2(depth);
    localparam int  pw    = aw + 1;
    localparam bit  op_ok = (op == "reg") || (op == "addi") || (op == "subi") || (op == "muli");
    localparam op_e op_sel = (op == "addi") ? OP_ADDI :
                             (op == "subi") ? OP_SUBI :
                             (op == "muli") ? OP_MULI : OP_REG;

    if (!op_ok) begin : g_bad_op
        $error("async_fifo_operator: unsupported op");
    end
    if ((depth < 2) || ((1 << aw) != depth)) begin : g_bad_depth
        $error("async_fifo_operator: depth must be a power of two >= 2");
    end

    logic [data_width-1:0] mem_r [depth];
    logic [pw-1:0]         wr_ptr_r;
    logic                  req_l_r;
    logic [pw-1:0]         rd_ptr_s  [output_size];
    logic [pw-1:0]         cnt_s     [output_size];
    logic [data_width-1:0] rd_word_s [output_size];
    logic [pw-1:0]         occ_max_s;
    logic                  full_s;
    logic                  write_s;

    // The slowest consumer decides how many entries are still held.
    always_comb begin
        occ_max_s = '0;
        for (int k = 0; k < output_size; k++) begin
            if (cnt_s[k] > occ_max_s) begin
                occ_max_s = cnt_s[k];
            end else begin
                occ_max_s = occ_max_s;
            end
        end
    end

    assign full_s  = (occ_max_s == pw'(depth));
    assign write_s = ack_l && req_l_r;

    // Upstream handshake; a slot is reserved as soon as req_l rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            req_l_r  <= 1'b0;
        end else if (write_s) begin
            wr_ptr_r <= wr_ptr_r + pw'(1);
            req_l_r  <= 1'b0;
        end else if (!req_l_r && !full_s) begin
            req_l_r  <= 1'b1;
        end else begin
            req_l_r  <= req_l_r;
        end
    end

    // Token storage.
    always_ff @(posedge clk) begin
        if (write_s && !rst) begin
            mem_r[wr_ptr_r[aw-1:0]] <= din;
        end
    end

    for (genvar k = 0; k < output_size; k++) begin : g_port
        assign rd_word_s[k] = mem_r[rd_ptr_s[k][aw-1:0]];

        async_fifo_read_port #(
            .data_width (data_width),
            .ptr_width  (pw),
            .op_sel     (op_sel),
            .immediate  (immediate)
        ) u_port (
            .clk     (clk),
            .rst     (rst),
            .wr_ptr  (wr_ptr_r),
            .rd_word (rd_word_s[k]),
            .req     (req_r[k]),
            .rd_ptr  (rd_ptr_s[k]),
            .cnt     (cnt_s[k]),
            .ack     (ack_r[k]),
            .dout    (dout[k*data_width +: data_width])
        );
    end

    async_fifo_operator_chk #(
        .depth     (depth),
        .occ_width (pw)
    ) u_chk (
        .clk       (clk),
        .rst       (rst),
        .req_l     (req_l_r),
        .ack_l     (ack_l),
        .occupancy (occ_max_s)
    );

    assign req_l     = req_l_r;
    assign occupancy = occ_max_s;

endmodule

// File: doc/async_fifo_operator.md
Name: async_fifo_operator

Overview:
- Parametrised successor to the single-entry handshake operator node of the dataflow fabric.
- Buffers up to `depth` tokens between one producer and `output_size` consumers, using the same req/ack pull handshake.
- Fans out independently per consumer (lazy fork): a slow consumer does not stall the others until the buffer fills.
- Applies an optional unary immediate op on the read path. Replaces chains of single-entry "reg" nodes inserted for path balancing.

Parameters:
- data_width, 32, token width in bits.
- depth, 4, buffer entries; power of two, ≥2.
- output_size, 1, number of independent consumers, ≥1.
- op, "reg", read-path op: "reg", "addi", "subi", "muli"; any other value is an elaboration error.
- immediate, 0, operand for addi/subi/muli.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- req_l  out  1  request to upstream for one token.
- ack_l  in  1  upstream one-cycle ack; din valid in that cycle.
- din  in  data_width  upstream token.
- req_r  in  output_size  per-consumer request.
- ack_r  out  output_size  per-consumer one-cycle ack.
- dout  out  data_width*output_size  per-consumer token; slice k belongs to consumer k.
- occupancy  out  clog2(depth)+1  entries still unread by the slowest consumer.

Behaviour:
- Reset: req_l=0, ack_r=0, dout=0, occupancy=0. Write pointer and all read pointers are cleared. Reset mid-operation drops all buffered tokens and any outstanding request. The first req_l rises on the first cycle after rst is deasserted.
- Storage and pointers:
  - mem[depth] holds tokens.
  - wr_ptr and rd_ptr[k] are clog2(depth)+1 bits; the extra bit is the wrap flag.
  - cnt[k] = wr_ptr - rd_ptr[k], computed modulo 2^(clog2(depth)+1).
  - occupancy = max over k of cnt[k].
  - full = (occupancy == depth). Empty for consumer k = (cnt[k] == 0).
- Input side (registered):
  - If ack_l: write din to mem[wr_ptr], increment wr_ptr, and set req_l to 0 on the next cycle.
  - Else if !req_l and occupancy < depth: set req_l to 1.
  - Else hold req_l.
  - The slot is reserved when req_l rises, so ack_l can never overflow. Reads only reduce occupancy.
  - ack_l while req_l=0 is a protocol violation: assert in simulation and ignore.
- Output side, for each consumer k (registered):
  - If req_r[k] and cnt[k] > 0 and !ack_r[k]: set ack_r[k]=1, dout[k]=f(mem[rd_ptr[k]]), and increment rd_ptr[k].
  - Else set ack_r[k]=0.
  - ack_r[k] is never high on two consecutive cycles.
  - dout[k] holds its value after the ack.
- f() on the read path:
  - reg: pass-through.
  - addi / subi / muli: x op immediate, truncated modulo 2^data_width with no saturation.
- Latency:
  - ack_l in cycle t → token readable in cycle t+1 → earliest ack_r in cycle t+2. There is no same-cycle bypass.
  - Steady-state input rate is 1 token per 2 cycles.
  - Each consumer can take 1 token per 2 cycles.
- Simultaneous events:
  - A write and any set of reads in the same cycle are all performed.
  - Occupancy reflects both in the following cycle.
  - A read of the entry being written in that cycle is not possible, because cnt[k] is checked before the write.
- Entry release: an entry is freed only when every consumer's rd_ptr has passed it. Occupancy is governed by the slowest consumer.
- Wrap-around: pointers wrap naturally at 2·depth. full and empty are distinguished by the MSB.

Decomposition:
- Shared package `async_pkg`:
  - op encoding constants (OP_REG, OP_ADDI, OP_SUBI, OP_MULI);
  - a clog2 function;
  - a function that applies an op encoding to data_width-bit data.
- Sub-module `async_fifo_read_port`, one instance per consumer:
  - contains rd_ptr, the cnt/empty compare, ack_r/dout registers and f();
  - takes wr_ptr and the mem read word as inputs;
  - generated output_size times.

Test Plan:
- Reset mid-stream: depth=4, 3 tokens buffered, pulse rst → next cycle occupancy=0, ack_r=0, dout=0; the next token accepted is the next producer value and read back first.
- Single-token latency: output_size=1, consumer always requesting, producer sends 7 → ack_r high exactly 2 cycles after ack_l with dout=7. 5000 tokens 0..4999 arrive in order.
- Fill to full: depth=4, consumer idle, producer sends 10,11,12,13 → occupancy=4 and req_l stays 0. One consumer ack (dout=10) → req_l rises again and token 14 is accepted into the wrapped slot.
- Lazy fork: output_size=2, consumer 0 always requesting, consumer 1 idle, tokens 0..5 →
  - consumer 0 receives 0,1,2,3;
  - occupancy saturates at 4 and input stalls;
  - enabling consumer 1 then yields 0,1,2,3,4,5 on both, with no loss or duplication.
- Op path: op="addi", immediate=2, data_width=8, inputs 0, 253, 255 → dout 2, 255, 1 (wrap modulo 256).
- Random stress: fail rate 50% at producer and at each of 3 consumers, depth=8, 5000 tokens →
  - each consumer sees the exact increasing sequence;
  - ack_r is never high on back-to-back cycles;
  - occupancy never exceeds 8.
